// File: rtl/remote_comm.sv
// Knight's Tour host link: sends a 16-bit command as two UART frames (high byte first) and receives 1-byte responses.
// TX start bit 1 clk after accept, cmd_sent 20*BAUD_DIV clks later; snd_cmd ignored while busy, resp held until cleared.
module remote_comm #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_sent,
  output logic        busy,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy,
  output logic        frm_err
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, SEND_HI, SEND_LO} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, START, DATA, STOP} rx_state_t;

  tx_state_t       tx_state;
  logic [15:0]     tx_cmd;
  logic [3:0]      tx_bit;
  logic [CW-1:0]   tx_baud;
  logic [7:0]      tx_byte;

  rx_state_t       rx_state;
  logic            rx_s1, rx_s2, rx_prev;
  logic [2:0]      rx_bit;
  logic [CW-1:0]   rx_baud;
  logic [7:0]      rx_shift;

  assign tx_byte = (tx_state == SEND_HI) ? tx_cmd[15:8] : tx_cmd[7:0];

  // tx_bit indexes the bit currently on the line: 0 start, 1..8 data, 9 stop
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      TX       <= 1'b1;
      busy     <= 1'b0;
      cmd_sent <= 1'b0;
      tx_cmd   <= '0;
      tx_bit   <= '0;
      tx_baud  <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (snd_cmd) begin
            tx_cmd   <= cmd;
            busy     <= 1'b1;
            cmd_sent <= 1'b0;
            TX       <= 1'b0;
            tx_bit   <= '0;
            tx_baud  <= '0;
            tx_state <= SEND_HI;
          end
        end
        default: begin
          if (tx_baud == BIT_END) begin
            tx_baud <= '0;
            if (tx_bit == 4'd9) begin
              tx_bit <= '0;
              if (tx_state == SEND_HI) begin
                tx_state <= SEND_LO;
                TX       <= 1'b0;
              end else begin
                tx_state <= TX_IDLE;
                busy     <= 1'b0;
                cmd_sent <= 1'b1;
                TX       <= 1'b1;
              end
            end else begin
              tx_bit <= tx_bit + 4'd1;
              TX     <= (tx_bit < 4'd8) ? tx_byte[tx_bit[2:0]] : 1'b1;
            end
          end else begin
            tx_baud <= tx_baud + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_bit   <= '0;
      rx_baud  <= '0;
      rx_shift <= '0;
      resp     <= '0;
      resp_rdy <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      frm_err <= 1'b0;
      if (clr_resp_rdy) resp_rdy <= 1'b0;
      // later assignments below let a new byte win over a same-cycle clear
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_baud  <= '0;
            rx_state <= START;
          end
        end
        START: begin
          if (rx_baud == HALF_END) begin
            rx_baud <= '0;
            if (rx_s2) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= DATA;
              rx_bit   <= '0;
              resp_rdy <= 1'b0;
            end
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
        DATA: begin
          if (rx_baud == BIT_END) begin
            rx_baud  <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= STOP;
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
        default: begin
          if (rx_baud == BIT_END) begin
            rx_baud  <= '0;
            rx_state <= RX_IDLE;
            if (rx_s2) begin
              resp     <= rx_shift;
              resp_rdy <= 1'b1;
            end else begin
              frm_err  <= 1'b1;
            end
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm with BAUD_DIV=16: TX frame decoder plus byte scoreboards for both directions.
module tb_remote_comm;
  localparam int BD = 16;

  logic        clk, rst, snd_cmd, clr_resp_rdy, rx_drv, loop;
  logic [15:0] cmd;
  logic        cmd_sent, busy, TX, RX, resp_rdy, frm_err;
  logic [7:0]  resp;

  int nchecks = 0;
  int nerr    = 0;
  int cyc     = 0;
  int ferr_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] mon_q[$];
  logic       mon_ok[$];
  int         mon_t[$];

  assign RX = loop ? TX : rx_drv;

  remote_comm #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .snd_cmd(snd_cmd), .cmd_sent(cmd_sent),
    .busy(busy), .TX(TX), .RX(RX), .resp(resp), .resp_rdy(resp_rdy),
    .clr_resp_rdy(clr_resp_rdy), .frm_err(frm_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (frm_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1);
  end

  // TX decoder: samples each bit in its middle, drops a frame cut short by reset
  initial begin
    logic [9:0] fb;
    logic       abort;
    int         t0;
    forever begin
      @(posedge clk); #2;
      if (!rst && TX === 1'b0) begin
        t0 = cyc; abort = 1'b0; fb = '0;
        for (int k = 1; k <= 152; k++) begin
          @(posedge clk); #2;
          if (rst) begin abort = 1'b1; break; end
          if (k >= 8 && (k - 8) % 16 == 0) fb[(k - 8) / 16] = TX;
        end
        if (!abort) begin
          mon_q.push_back(fb[8:1]);
          mon_ok.push_back(fb[0] == 1'b0 && fb[9] == 1'b1);
          mon_t.push_back(t0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_tx(input string tag, output int t);
    int w = 0;
    t = -1;
    while (mon_q.size() == 0 && w < 400) begin tick(); w++; end
    if (mon_q.size() == 0) begin
      chk({tag, "_timeout"}, mon_q.size(), 1);
    end else begin
      t = mon_t.pop_front();
      chk({tag, "_framing"}, mon_ok.pop_front(), 1);
      chk(tag, mon_q.pop_front(), exp_q.pop_front());
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    if (stop_bit) exp_rx_q.push_back(b);
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (BD) tick();
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_rdy(input string tag);
    int w = 0;
    while (resp_rdy !== 1'b1 && w < 400) begin tick(); w++; end
    chk({tag, "_rdy"}, resp_rdy, 1);
    chk(tag, resp, exp_rx_q.pop_front());
    clr_resp_rdy = 1'b1;
    tick();
    clr_resp_rdy = 1'b0;
    chk({tag, "_clr"}, resp_rdy, 0);
  endtask

  initial begin
    int t_fall, t0, t1, busy_n, sent_at, ferr0;
    logic [7:0] last_good;

    rst = 1'b1; snd_cmd = 1'b0; clr_resp_rdy = 1'b0; rx_drv = 1'b1; loop = 1'b0; cmd = '0;
    repeat (3) tick();
    chk("rst_tx", TX, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_sent", cmd_sent, 0);
    chk("rst_resp", resp, 8'h00);
    chk("rst_resp_rdy", resp_rdy, 0);
    chk("rst_frm_err", frm_err, 0);
    rst = 1'b0;
    repeat (2) tick();

    // command 0x1234 with an ignored request mid-transfer
    cmd = 16'h1234; snd_cmd = 1'b1;
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    tick();
    snd_cmd = 1'b0;
    t_fall = cyc;
    chk("tx_start", TX, 0);
    chk("busy_set", busy, 1);
    chk("cmd_sent_clr", cmd_sent, 0);
    busy_n = 1; sent_at = -1;
    for (int i = 1; i <= 330; i++) begin
      if (i == 100) begin cmd = 16'hFFFF; snd_cmd = 1'b1; end
      else snd_cmd = 1'b0;
      tick();
      if (busy) busy_n++;
      if (cmd_sent && sent_at < 0) sent_at = i;
    end
    chk("busy_len", busy_n, 320);
    chk("cmd_sent_at", sent_at, 320);
    chk("cmd_sent_hold", cmd_sent, 1);
    chk("busy_done", busy, 0);
    pop_tx("tx_hi", t0);
    pop_tx("tx_lo", t1);
    chk("hi_fall_time", t0, t_fall);
    chk("frame_gap", t1 - t0, 160);

    // good response byte
    send_rx(8'hA5, 1'b1);
    last_good = 8'hA5;
    chk("rx_rdy", resp_rdy, 1);
    chk("rx_a5", resp, exp_rx_q.pop_front());
    repeat (50) tick();
    chk("rx_rdy_hold", resp_rdy, 1);
    clr_resp_rdy = 1'b1;
    tick();
    clr_resp_rdy = 1'b0;
    chk("rx_rdy_clr", resp_rdy, 0);

    // framing error keeps the last good byte
    ferr0 = ferr_cnt;
    send_rx(8'hFF, 1'b0);
    repeat (10) tick();
    chk("ferr_pulse", ferr_cnt - ferr0, 1);
    chk("ferr_resp", resp, last_good);
    chk("ferr_rdy", resp_rdy, 0);

    // short glitch is a false start
    ferr0 = ferr_cnt;
    rx_drv = 1'b0;
    repeat (4) tick();
    rx_drv = 1'b1;
    repeat (30) tick();
    chk("glitch_rdy", resp_rdy, 0);
    chk("glitch_ferr", ferr_cnt - ferr0, 0);
    send_rx(8'h00, 1'b1);
    chk("rx00_rdy", resp_rdy, 1);
    chk("rx00", resp, exp_rx_q.pop_front());
    clr_resp_rdy = 1'b1;
    tick();
    clr_resp_rdy = 1'b0;

    // loopback
    loop = 1'b1;
    repeat (5) tick();
    cmd = 16'h5AC3; snd_cmd = 1'b1;
    exp_q.push_back(8'h5A); exp_q.push_back(8'hC3);
    exp_rx_q.push_back(8'h5A); exp_rx_q.push_back(8'hC3);
    tick();
    snd_cmd = 1'b0;
    wait_rdy("loop_5a");
    wait_rdy("loop_c3");
    pop_tx("loop_tx_hi", t0);
    pop_tx("loop_tx_lo", t1);
    repeat (40) tick();
    loop = 1'b0;
    repeat (5) tick();

    // reset during a frame, then a clean transfer
    cmd = 16'h1234; snd_cmd = 1'b1;
    tick();
    snd_cmd = 1'b0;
    repeat (149) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_tx", TX, 1);
    chk("abort_busy", busy, 0);
    chk("abort_cmd_sent", cmd_sent, 0);
    repeat (3) tick();
    chk("abort_no_byte", mon_q.size(), 0);
    cmd = 16'h00FF; snd_cmd = 1'b1;
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    tick();
    snd_cmd = 1'b0;
    repeat (330) tick();
    chk("post_rst_sent", cmd_sent, 1);
    pop_tx("post_rst_hi", t0);
    pop_tx("post_rst_lo", t1);
    chk("post_rst_gap", t1 - t0, 160);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
